// File: rtl/axi_master_arbiter_pkg.sv
// Shared types and sizing helpers for the AXI master arbiter.
// The two channel FSMs and the bus-ID width live here.
package axi_arb_pkg;

   typedef enum logic [1:0] {
      W_IDLE = 2'd0,
      W_ADDR = 2'd1,
      W_DATA = 2'd2,
      W_RESP = 2'd3
   } wr_state_t;

   typedef enum logic [1:0] {
      R_IDLE = 2'd0,
      R_ADDR = 2'd1,
      R_DATA = 2'd2
   } rd_state_t;

   // The bus ID carries the master index above the per-master ID bits.
   function automatic int bus_id_w(input int m_width, input int m_id);
      return m_id + m_width;
   endfunction

endpackage

// File: rtl/axi_master_arbiter_if.sv
// Control-side bundle between the arbiter and the surrounding switch and bus.
// The master modport is the arbiter; the slave modport is whoever drives the bus.
interface axi_master_arbiter_if #(
   parameter int M_WIDTH = 2,
   parameter int M_ID    = 2
);
   import axi_arb_pkg::*;

   localparam int N    = 2 ** M_WIDTH;
   localparam int ID_W = bus_id_w(M_WIDTH, M_ID);

   logic [N-1:0]       MASTER_WR_ADDR_VALID;
   logic [N-1:0]       MASTER_RD_ADDR_VALID;
   logic               BUS_WR_ADDR_VALID, BUS_WR_ADDR_READY;
   logic               BUS_WR_DATA_VALID, BUS_WR_DATA_READY, BUS_WR_DATA_LAST;
   logic               BUS_WR_BACK_VALID, BUS_WR_BACK_READY;
   logic [ID_W-1:0]    BUS_WR_BACK_ID;
   logic               BUS_RD_ADDR_VALID, BUS_RD_ADDR_READY;
   logic               BUS_RD_DATA_VALID, BUS_RD_DATA_READY, BUS_RD_DATA_LAST;
   logic [ID_W-1:0]    BUS_RD_BACK_ID;

   logic [M_WIDTH-1:0] wr_addr_sel, wr_data_sel, wr_resp_sel, rd_addr_sel, rd_data_sel;
   logic               wr_addr_en, wr_data_en, wr_resp_en, rd_addr_en, rd_data_en;
   logic               wr_id_err, rd_id_err;

   modport master (
      input  MASTER_WR_ADDR_VALID, MASTER_RD_ADDR_VALID,
      input  BUS_WR_ADDR_VALID, BUS_WR_ADDR_READY,
      input  BUS_WR_DATA_VALID, BUS_WR_DATA_READY, BUS_WR_DATA_LAST,
      input  BUS_WR_BACK_VALID, BUS_WR_BACK_READY, BUS_WR_BACK_ID,
      input  BUS_RD_ADDR_VALID, BUS_RD_ADDR_READY,
      input  BUS_RD_DATA_VALID, BUS_RD_DATA_READY, BUS_RD_DATA_LAST, BUS_RD_BACK_ID,
      output wr_addr_sel, wr_data_sel, wr_resp_sel, rd_addr_sel, rd_data_sel,
      output wr_addr_en, wr_data_en, wr_resp_en, rd_addr_en, rd_data_en,
      output wr_id_err, rd_id_err
   );

   modport slave (
      output MASTER_WR_ADDR_VALID, MASTER_RD_ADDR_VALID,
      output BUS_WR_ADDR_VALID, BUS_WR_ADDR_READY,
      output BUS_WR_DATA_VALID, BUS_WR_DATA_READY, BUS_WR_DATA_LAST,
      output BUS_WR_BACK_VALID, BUS_WR_BACK_READY, BUS_WR_BACK_ID,
      output BUS_RD_ADDR_VALID, BUS_RD_ADDR_READY,
      output BUS_RD_DATA_VALID, BUS_RD_DATA_READY, BUS_RD_DATA_LAST, BUS_RD_BACK_ID,
      input  wr_addr_sel, wr_data_sel, wr_resp_sel, rd_addr_sel, rd_data_sel,
      input  wr_addr_en, wr_data_en, wr_resp_en, rd_addr_en, rd_data_en,
      input  wr_id_err, rd_id_err
   );

endinterface

// File: rtl/axi_rr_arbiter.sv
// Combinational round-robin picker: first requester strictly after ptr wins,
// with ptr itself considered last.
module axi_rr_arbiter #(
   parameter int M_WIDTH = 2
) (
   input  logic [2**M_WIDTH-1:0] req,
   input  logic [M_WIDTH-1:0]    ptr,
   output logic [M_WIDTH-1:0]    grant,
   output logic                  valid
);
   localparam int N = 2 ** M_WIDTH;

   logic [M_WIDTH-1:0] idx;

   // Scan from farthest to nearest so the nearest requester is written last.
   always_comb begin
      grant = '0;
      valid = 1'b0;
      idx   = '0;
      for (int i = N; i >= 1; i--) begin
         idx = ptr + M_WIDTH'(i);
         if (req[idx]) begin
            grant = idx;
            valid = 1'b1;
         end
      end
   end

endmodule

// File: rtl/axi_master_arbiter.sv
// Write/read arbitration for the shared AXI bus: one transaction in flight per
// direction, round-robin grant, switch selects and channel enables, ID checks.
module axi_master_arbiter
   import axi_arb_pkg::*;
#(
   parameter int M_WIDTH = 2,
   parameter int M_ID    = 2
) (
   input  logic                 clk,
   input  logic                 rst,
   axi_master_arbiter_if.master bus
);
   localparam int ID_W = bus_id_w(M_WIDTH, M_ID);

   wr_state_t          wr_state_reg, wr_state_next;
   rd_state_t          rd_state_reg, rd_state_next;
   logic [M_WIDTH-1:0] wr_grant_reg, wr_grant_next, wr_ptr_reg, wr_ptr_next;
   logic [M_WIDTH-1:0] rd_grant_reg, rd_grant_next, rd_ptr_reg, rd_ptr_next;
   logic [M_WIDTH-1:0] wr_pick, rd_pick;
   logic               wr_pick_valid, rd_pick_valid;
   logic               aw_hs, w_last_hs, b_hs, ar_hs, r_hs;

   axi_rr_arbiter #(.M_WIDTH(M_WIDTH)) u_wr_rr (
      .req   (bus.MASTER_WR_ADDR_VALID),
      .ptr   (wr_ptr_reg),
      .grant (wr_pick),
      .valid (wr_pick_valid)
   );

   axi_rr_arbiter #(.M_WIDTH(M_WIDTH)) u_rd_rr (
      .req   (bus.MASTER_RD_ADDR_VALID),
      .ptr   (rd_ptr_reg),
      .grant (rd_pick),
      .valid (rd_pick_valid)
   );

   assign aw_hs     = bus.BUS_WR_ADDR_VALID & bus.BUS_WR_ADDR_READY;
   assign w_last_hs = bus.BUS_WR_DATA_VALID & bus.BUS_WR_DATA_READY & bus.BUS_WR_DATA_LAST;
   assign b_hs      = bus.BUS_WR_BACK_VALID & bus.BUS_WR_BACK_READY;
   assign ar_hs     = bus.BUS_RD_ADDR_VALID & bus.BUS_RD_ADDR_READY;
   assign r_hs      = bus.BUS_RD_DATA_VALID & bus.BUS_RD_DATA_READY;

   // Pointers reset to the last index so master 0 is first in line.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_state_reg <= W_IDLE;
         rd_state_reg <= R_IDLE;
         wr_grant_reg <= '0;
         rd_grant_reg <= '0;
         wr_ptr_reg   <= '1;
         rd_ptr_reg   <= '1;
      end else begin
         wr_state_reg <= wr_state_next;
         rd_state_reg <= rd_state_next;
         wr_grant_reg <= wr_grant_next;
         rd_grant_reg <= rd_grant_next;
         wr_ptr_reg   <= wr_ptr_next;
         rd_ptr_reg   <= rd_ptr_next;
      end
   end

   always_comb begin
      wr_state_next = wr_state_reg;
      wr_grant_next = wr_grant_reg;
      wr_ptr_next   = wr_ptr_reg;
      case (wr_state_reg)
         W_IDLE: if (wr_pick_valid) begin
            wr_grant_next = wr_pick;
            wr_ptr_next   = wr_pick;
            wr_state_next = W_ADDR;
         end
         W_ADDR: if (aw_hs)     wr_state_next = W_DATA;
         W_DATA: if (w_last_hs) wr_state_next = W_RESP;
         W_RESP: if (b_hs)      wr_state_next = W_IDLE;
         default:               wr_state_next = W_IDLE;
      endcase
   end

   always_comb begin
      rd_state_next = rd_state_reg;
      rd_grant_next = rd_grant_reg;
      rd_ptr_next   = rd_ptr_reg;
      case (rd_state_reg)
         R_IDLE: if (rd_pick_valid) begin
            rd_grant_next = rd_pick;
            rd_ptr_next   = rd_pick;
            rd_state_next = R_ADDR;
         end
         R_ADDR: if (ar_hs) rd_state_next = R_DATA;
         R_DATA: if (r_hs && bus.BUS_RD_DATA_LAST) rd_state_next = R_IDLE;
         default:           rd_state_next = R_IDLE;
      endcase
   end

   // Selects follow the registered grant, so they hold their value through IDLE.
   assign bus.wr_addr_sel = wr_grant_reg;
   assign bus.wr_data_sel = wr_grant_reg;
   assign bus.wr_resp_sel = wr_grant_reg;
   assign bus.rd_addr_sel = rd_grant_reg;
   assign bus.rd_data_sel = rd_grant_reg;

   assign bus.wr_addr_en  = (wr_state_reg == W_ADDR);
   assign bus.wr_data_en  = (wr_state_reg == W_DATA);
   assign bus.wr_resp_en  = (wr_state_reg == W_RESP);
   assign bus.rd_addr_en  = (rd_state_reg == R_ADDR);
   assign bus.rd_data_en  = (rd_state_reg == R_DATA);

   assign bus.wr_id_err = (wr_state_reg == W_RESP) && b_hs &&
                          (bus.BUS_WR_BACK_ID[ID_W-1 -: M_WIDTH] != wr_grant_reg);
   assign bus.rd_id_err = (rd_state_reg == R_DATA) && r_hs &&
                          (bus.BUS_RD_BACK_ID[ID_W-1 -: M_WIDTH] != rd_grant_reg);

endmodule

// File: tb/tb_axi_master_arbiter.sv
// Directed bench for axi_master_arbiter with M_WIDTH=2, M_ID=2.
// Inputs change 1ns after the rising edge; outputs are checked 1ns later.
module tb_axi_master_arbiter;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   vec_count  = 0;
   int   miss_count = 0;

   always #5 clk = ~clk;

   axi_master_arbiter_if #(.M_WIDTH(2), .M_ID(2)) bus_if ();

   axi_master_arbiter #(.M_WIDTH(2), .M_ID(2)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus_if)
   );

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      vec_count++;
      if (got !== exp) begin
         miss_count++;
         $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
      end else begin
         $display("ok   %s = 0x%0h", tag, got);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic settle();
      #1;
   endtask

   task automatic clear_bus();
      bus_if.MASTER_WR_ADDR_VALID = '0;
      bus_if.MASTER_RD_ADDR_VALID = '0;
      bus_if.BUS_WR_ADDR_VALID = 0; bus_if.BUS_WR_ADDR_READY = 0;
      bus_if.BUS_WR_DATA_VALID = 0; bus_if.BUS_WR_DATA_READY = 0; bus_if.BUS_WR_DATA_LAST = 0;
      bus_if.BUS_WR_BACK_VALID = 0; bus_if.BUS_WR_BACK_READY = 0; bus_if.BUS_WR_BACK_ID = '0;
      bus_if.BUS_RD_ADDR_VALID = 0; bus_if.BUS_RD_ADDR_READY = 0;
      bus_if.BUS_RD_DATA_VALID = 0; bus_if.BUS_RD_DATA_READY = 0; bus_if.BUS_RD_DATA_LAST = 0;
      bus_if.BUS_RD_BACK_ID = '0;
   endtask

   function automatic logic [31:0] out_vec();
      return {15'd0,
              bus_if.wr_addr_sel, bus_if.wr_data_sel, bus_if.wr_resp_sel,
              bus_if.rd_addr_sel, bus_if.rd_data_sel,
              bus_if.wr_addr_en, bus_if.wr_data_en, bus_if.wr_resp_en,
              bus_if.rd_addr_en, bus_if.rd_data_en,
              bus_if.wr_id_err, bus_if.rd_id_err};
   endfunction

   // Full write: caller has the request up and the FSM in IDLE.
   task automatic do_write(input string tag, input int exp_sel, input int beats,
                           input logic [3:0] bid, input logic exp_err);
      step();
      check_val({tag, " aw_en"}, 32'(bus_if.wr_addr_en), 32'd1);
      check_val({tag, " aw_sel"}, 32'(bus_if.wr_addr_sel), 32'(exp_sel));
      bus_if.BUS_WR_ADDR_VALID = 1; bus_if.BUS_WR_ADDR_READY = 1;
      step();
      bus_if.BUS_WR_ADDR_VALID = 0; bus_if.BUS_WR_ADDR_READY = 0;
      check_val({tag, " w_en"}, 32'(bus_if.wr_data_en), 32'd1);
      bus_if.BUS_WR_DATA_VALID = 1; bus_if.BUS_WR_DATA_READY = 1;
      for (int b = 0; b < beats; b++) begin
         bus_if.BUS_WR_DATA_LAST = (b == beats - 1);
         step();
      end
      bus_if.BUS_WR_DATA_VALID = 0; bus_if.BUS_WR_DATA_READY = 0; bus_if.BUS_WR_DATA_LAST = 0;
      check_val({tag, " b_en"}, 32'(bus_if.wr_resp_en), 32'd1);
      check_val({tag, " b_sel"}, 32'(bus_if.wr_resp_sel), 32'(exp_sel));
      bus_if.BUS_WR_BACK_VALID = 1; bus_if.BUS_WR_BACK_READY = 1; bus_if.BUS_WR_BACK_ID = bid;
      settle();
      check_val({tag, " wr_err"}, 32'(bus_if.wr_id_err), 32'(exp_err));
      step();
      check_val({tag, " wr_err_gone"}, 32'(bus_if.wr_id_err), 32'd0);
      bus_if.BUS_WR_BACK_VALID = 0; bus_if.BUS_WR_BACK_READY = 0;
      check_val({tag, " idle"}, 32'({bus_if.wr_addr_en, bus_if.wr_data_en, bus_if.wr_resp_en}), 32'd0);
   endtask

   initial begin
      clear_bus();
      #3;
      check_val("reset outputs", out_vec(), 32'd0);
      @(posedge clk); #1;
      rst = 0;

      // Single write from master 2, four beats, matching B ID.
      bus_if.MASTER_WR_ADDR_VALID = 4'b0100;
      settle();
      check_val("t1 aw_en before edge", 32'(bus_if.wr_addr_en), 32'd0);
      do_write("t1", 2, 4, 4'b1001, 1'b0);
      bus_if.MASTER_WR_ADDR_VALID = '0;
      check_val("t1 sel hold", 32'(bus_if.wr_addr_sel), 32'd2);

      // Fairness: 0,1,3 requesting continuously; ptr is 2 after t1 so 3 leads,
      // then 0, 1, 3, 0, 1.
      bus_if.MASTER_WR_ADDR_VALID = 4'b1011;
      do_write("rr0", 3, 1, 4'b1100, 1'b0);
      do_write("rr1", 0, 1, 4'b0000, 1'b0);
      do_write("rr2", 1, 1, 4'b0100, 1'b0);
      do_write("rr3", 3, 1, 4'b1110, 1'b0);
      do_write("rr4", 0, 1, 4'b0011, 1'b0);
      do_write("rr5", 1, 1, 4'b0101, 1'b0);
      bus_if.MASTER_WR_ADDR_VALID = '0;

      // Write ID error: grant 1, B returns top bits 3.
      bus_if.MASTER_WR_ADDR_VALID = 4'b0010;
      do_write("wid", 1, 2, 4'b1101, 1'b1);
      bus_if.MASTER_WR_ADDR_VALID = '0;

      // Concurrent: master 1 writes, master 0 reads.
      step();
      bus_if.MASTER_WR_ADDR_VALID = 4'b0010;
      bus_if.MASTER_RD_ADDR_VALID = 4'b0001;
      step();
      bus_if.MASTER_WR_ADDR_VALID = '0;
      bus_if.MASTER_RD_ADDR_VALID = '0;
      check_val("cc en pair", 32'({bus_if.wr_addr_en, bus_if.rd_addr_en}), 32'd3);
      check_val("cc sels", 32'({bus_if.wr_addr_sel, bus_if.rd_addr_sel}), 32'b0100);
      bus_if.BUS_WR_ADDR_VALID = 1; bus_if.BUS_WR_ADDR_READY = 1;
      bus_if.BUS_RD_ADDR_VALID = 1; bus_if.BUS_RD_ADDR_READY = 1;
      step();
      bus_if.BUS_WR_ADDR_VALID = 0; bus_if.BUS_WR_ADDR_READY = 0;
      bus_if.BUS_RD_ADDR_VALID = 0; bus_if.BUS_RD_ADDR_READY = 0;
      check_val("cc data en", 32'({bus_if.wr_data_en, bus_if.rd_data_en}), 32'd3);
      check_val("cc data sels", 32'({bus_if.wr_data_sel, bus_if.rd_data_sel}), 32'b0100);
      // W single beat with LAST; first R beat carries a wrong ID (top bits 2).
      bus_if.BUS_WR_DATA_VALID = 1; bus_if.BUS_WR_DATA_READY = 1; bus_if.BUS_WR_DATA_LAST = 1;
      bus_if.BUS_RD_DATA_VALID = 1; bus_if.BUS_RD_DATA_READY = 1; bus_if.BUS_RD_DATA_LAST = 0;
      bus_if.BUS_RD_BACK_ID = 4'b1001;
      settle();
      check_val("rid bad beat err", 32'(bus_if.rd_id_err), 32'd1);
      step();
      bus_if.BUS_WR_DATA_VALID = 0; bus_if.BUS_WR_DATA_READY = 0; bus_if.BUS_WR_DATA_LAST = 0;
      bus_if.BUS_RD_BACK_ID = 4'b0010;
      bus_if.BUS_RD_DATA_LAST = 1;
      bus_if.BUS_WR_BACK_VALID = 1; bus_if.BUS_WR_BACK_READY = 1; bus_if.BUS_WR_BACK_ID = 4'b0111;
      settle();
      check_val("cc resp/rdata en", 32'({bus_if.wr_resp_en, bus_if.rd_data_en}), 32'd3);
      check_val("cc errs clean", 32'({bus_if.wr_id_err, bus_if.rd_id_err}), 32'd0);
      step();
      clear_bus();
      check_val("cc all en low", out_vec() & 32'h7C, 32'd0);

      // Async reset mid-burst in W_DATA.
      bus_if.MASTER_WR_ADDR_VALID = 4'b0100;
      step();
      bus_if.MASTER_WR_ADDR_VALID = '0;
      bus_if.BUS_WR_ADDR_VALID = 1; bus_if.BUS_WR_ADDR_READY = 1;
      step();
      bus_if.BUS_WR_ADDR_VALID = 0; bus_if.BUS_WR_ADDR_READY = 0;
      bus_if.BUS_WR_DATA_VALID = 1; bus_if.BUS_WR_DATA_READY = 1;
      step();
      check_val("ar pre-reset w_en", 32'(bus_if.wr_data_en), 32'd1);
      #1 rst = 1;
      #1;
      check_val("ar async outputs", out_vec(), 32'd0);
      step();
      clear_bus();
      rst = 0;
      bus_if.MASTER_WR_ADDR_VALID = 4'b1111;
      step();
      bus_if.MASTER_WR_ADDR_VALID = '0;
      check_val("ar first grant", 32'({bus_if.wr_addr_en, bus_if.wr_addr_sel}), 32'b100);

      // Backpressure on W with master 0 granted.
      bus_if.BUS_WR_ADDR_VALID = 1; bus_if.BUS_WR_ADDR_READY = 1;
      step();
      bus_if.BUS_WR_ADDR_VALID = 0; bus_if.BUS_WR_ADDR_READY = 0;
      bus_if.BUS_WR_DATA_VALID = 1; bus_if.BUS_WR_DATA_READY = 0; bus_if.BUS_WR_DATA_LAST = 1;
      for (int c = 0; c < 5; c++) begin
         step();
         check_val($sformatf("bp hold %0d", c),
                   32'({bus_if.wr_data_en, bus_if.wr_data_sel, bus_if.wr_resp_en}), 32'b1000);
      end
      bus_if.BUS_WR_DATA_READY = 1; bus_if.BUS_WR_DATA_LAST = 0;
      step();
      check_val("bp no-last stays", 32'({bus_if.wr_data_en, bus_if.wr_resp_en}), 32'b10);
      bus_if.BUS_WR_DATA_LAST = 1;
      step();
      bus_if.BUS_WR_DATA_VALID = 0; bus_if.BUS_WR_DATA_READY = 0; bus_if.BUS_WR_DATA_LAST = 0;
      check_val("bp to resp", 32'({bus_if.wr_data_en, bus_if.wr_resp_en, bus_if.wr_resp_sel}), 32'b0100);
      bus_if.BUS_WR_BACK_VALID = 1; bus_if.BUS_WR_BACK_READY = 1; bus_if.BUS_WR_BACK_ID = 4'b0001;
      step();
      clear_bus();
      check_val("bp done idle", 32'(bus_if.wr_resp_en), 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", vec_count, miss_count);
      $finish;
   end

endmodule

// File: doc/axi_master_arbiter.md
Name: axi_master_arbiter

Overview:
- Control stage directly upstream of axi_master_switch.
- Arbitrates between 2**M_WIDTH AXI masters for the shared bus, independently for the write path and the read path.
- Drives the switch's five select lines and the channel-enable strobes that the top level uses to gate bus VALID/READY.
- Single outstanding transaction per direction; round-robin fairness; checks that returned IDs match the granted master.

Parameters:
- M_WIDTH, 2, log2 of master count; select width.
- M_ID, 2, per-master ID width; bus ID width is M_ID+M_WIDTH, with the master index in the top M_WIDTH bits.

Ports:
- clk  in  1  clock.
- rst  in  1  reset; asynchronous, active-high.
- MASTER_WR_ADDR_VALID  in  2**M_WIDTH  per-master write request.
- MASTER_RD_ADDR_VALID  in  2**M_WIDTH  per-master read request.
- BUS_WR_ADDR_VALID, BUS_WR_ADDR_READY  in  1 each  gated AW handshake observed on the bus.
- BUS_WR_DATA_VALID, BUS_WR_DATA_READY, BUS_WR_DATA_LAST  in  1 each  gated W handshake.
- BUS_WR_BACK_VALID, BUS_WR_BACK_READY  in  1 each  gated B handshake.
- BUS_WR_BACK_ID  in  M_ID+M_WIDTH  B ID.
- BUS_RD_ADDR_VALID, BUS_RD_ADDR_READY  in  1 each  gated AR handshake.
- BUS_RD_DATA_VALID, BUS_RD_DATA_READY, BUS_RD_DATA_LAST  in  1 each  gated R handshake.
- BUS_RD_BACK_ID  in  M_ID+M_WIDTH  R ID.
- wr_addr_sel, wr_data_sel, wr_resp_sel, rd_addr_sel, rd_data_sel  out  M_WIDTH each  switch selects.
- wr_addr_en, wr_data_en, wr_resp_en, rd_addr_en, rd_data_en  out  1 each  channel open. Top level ANDs each enable into the bus VALID and the master READY of that channel.
- wr_id_err, rd_id_err  out  1 each  one-cycle pulse on ID mismatch.

Behaviour:
- Reset:
  - All sel, en and err outputs go to 0.
  - Both FSMs go to IDLE.
  - Both round-robin pointers go to 2**M_WIDTH-1, so master 0 wins first.
- Reset mid-transaction: immediate return to reset state; the in-flight burst is abandoned and no err pulse is raised.
- Write FSM, states W_IDLE, W_ADDR, W_DATA, W_RESP:
  - W_IDLE: all write en = 0. If any MASTER_WR_ADDR_VALID is set, register grant = rr_pick(req, ptr), set ptr = grant, and go to W_ADDR on the next edge.
  - Latency from request to wr_addr_en is 1 cycle.
  - W_ADDR: wr_addr_sel = grant, wr_addr_en = 1. On BUS_WR_ADDR_VALID & READY, go to W_DATA.
  - W_DATA: wr_data_sel = grant, wr_data_en = 1, wr_addr_en = 0. On BUS_WR_DATA_VALID & READY & LAST, go to W_RESP.
  - W_RESP: wr_resp_sel = grant, wr_resp_en = 1. On BUS_WR_BACK_VALID & READY, go to W_IDLE.
  - W_RESP ID check: if BUS_WR_BACK_ID[top M_WIDTH] != grant at the B handshake, pulse wr_id_err for 1 cycle. The transaction still completes.
- W-before-AW data from a master is held off by wr_data_en = 0 until W_DATA; the write path is strictly serialized.
- Read FSM, states R_IDLE, R_ADDR, R_DATA:
  - R_IDLE and R_ADDR behave the same as the write FSM, using rd_addr_sel / rd_addr_en.
  - R_DATA: rd_data_sel = grant, rd_data_en = 1. Exit to R_IDLE on the R handshake with LAST.
  - R_DATA ID check: every R beat compares BUS_RD_BACK_ID top bits against grant. A mismatch pulses rd_id_err on that beat.
- Select hold: sel outputs keep their last grant value in IDLE; only en drops.
- Round robin: pick the first requester at index ptr+1, ptr+2, … modulo 2**M_WIDTH. If only one master requests, it wins repeatedly.
- Write and read FSMs are fully independent; simultaneous events on both paths are each handled in the same cycle.
- A master deasserting VALID in an ADDR state (protocol violation) leaves the FSM waiting in that state; there is no timeout.
- Minimum turnaround: one IDLE cycle between consecutive transactions on the same path.

Decomposition:
- Package axi_arb_pkg holds:
  - typedefs wr_state_t and rd_state_t;
  - constant BUS_ID_W = M_ID+M_WIDTH, provided as a function of the parameters.
- One sub-module, axi_rr_arbiter (req vector, ptr -> grant index plus valid; combinational picker), instantiated twice.

Test Plan:
- Single write, M_WIDTH=2: master 2 asserts AW valid with a LEN=3 burst.
  - wr_addr_en rises 1 cycle later with sel=2.
  - After 4 W beats with LAST, wr_resp_en=1.
  - B ID = {2'd2, id}: no err; FSM returns to IDLE.
- Fairness: masters 0, 1 and 3 request writes continuously. Grant order after reset is 0, 1, 3, 0, 1, 3; master 2 is never granted.
- Concurrent paths: master 1 writes while master 0 reads in the same cycle. Both addr_en rise together, and both complete with independent sels 1 and 0.
- ID error:
  - B returns with top bits 3 while grant=1: wr_id_err pulses exactly once and the FSM still returns to IDLE.
  - An R beat with a wrong ID pulses rd_id_err on that beat only.
- Async reset asserted in W_DATA mid-burst: all en, sel and err outputs are 0 without waiting for a clock edge. After release, master 0 requesting is granted first.
- Backpressure: BUS_WR_DATA_READY held low for 5 cycles in W_DATA. The state holds, wr_data_sel stays stable, and there is no early exit without LAST.
